// File: rtl/exe_pipeline_ctrl_if.sv
// Handshake/control bundle between the ARM execute stage and its sequencing controller.
// slave = controller side, master = pipeline/driver side.
interface exe_pipeline_ctrl_if;
  logic       id_valid;
  logic [3:0] src1;
  logic [3:0] src2;
  logic       two_src;
  logic       exe_wb_en;
  logic [3:0] exe_dest;
  logic       exe_mem_read;
  logic       mem_wb_en;
  logic [3:0] mem_dest;
  logic       branch_taken;
  logic       exe_s;
  logic       mem_req;
  logic       mem_ready;
  logic       hazard;
  logic       flush;
  logic       freeze;
  logic       status_ld;
  logic       timeout_err;
  logic [1:0] state;

  modport slave (
    input  id_valid, src1, src2, two_src, exe_wb_en, exe_dest, exe_mem_read,
           mem_wb_en, mem_dest, branch_taken, exe_s, mem_req, mem_ready,
    output hazard, flush, freeze, status_ld, timeout_err, state
  );

  modport master (
    output id_valid, src1, src2, two_src, exe_wb_en, exe_dest, exe_mem_read,
           mem_wb_en, mem_dest, branch_taken, exe_s, mem_req, mem_ready,
    input  hazard, flush, freeze, status_ld, timeout_err, state
  );
endinterface

// File: rtl/exe_pipeline_ctrl.sv
// Stall/flush/freeze sequencer beside EXE; flush/freeze are Moore (1 cycle after cause), hazard/status_ld Mealy.
// Freezes the whole pipe while an SRAM access is outstanding; define FORWARDING_EN to stall on load-use only.
module exe_pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  exe_pipeline_ctrl_if.slave pif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FLUSH_INIT   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend, pend_nxt;
  logic             raw_match;

`ifdef FORWARDING_EN
  // Forwarding covers everything except a load whose data is not yet out of MEM.
  logic load_use;
  assign load_use = pif.exe_mem_read & pif.exe_wb_en &
                    ((pif.src1 == pif.exe_dest) | (pif.two_src & (pif.src2 == pif.exe_dest)));
  assign raw_match = pif.id_valid & load_use;
`else
  logic hit1, hit2;
  assign hit1 = (pif.exe_wb_en & (pif.src1 == pif.exe_dest)) |
                (pif.mem_wb_en & (pif.src1 == pif.mem_dest));
  assign hit2 = (pif.exe_wb_en & (pif.src2 == pif.exe_dest)) |
                (pif.mem_wb_en & (pif.src2 == pif.mem_dest));
  assign raw_match = pif.id_valid & (hit1 | (pif.two_src & hit2));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= RUN;
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      cur  <= nxt;
      cnt  <= cnt_nxt;
      pend <= pend_nxt;
    end
  end

  always_comb begin
    nxt      = cur;
    cnt_nxt  = cnt;
    pend_nxt = pend;
    case (cur)
      RUN: begin
        if (pif.mem_req) begin
          nxt      = MEM_WAIT;
          cnt_nxt  = '0;
          pend_nxt = pif.branch_taken;
        end else if (pif.branch_taken) begin
          nxt     = FLUSH;
          cnt_nxt = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (cnt == '0) nxt = RUN;
        else           cnt_nxt = cnt - 1'b1;
      end
      MEM_WAIT: begin
        // A branch resolved alongside the access is flushed only once memory returns.
        if (pif.mem_ready) begin
          if (pend) begin
            nxt      = FLUSH;
            cnt_nxt  = FLUSH_INIT;
            pend_nxt = 1'b0;
          end else begin
            nxt = RUN;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          nxt = ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ERR: nxt = ERR;
      default: nxt = RUN;
    endcase
  end

  assign pif.state       = cur;
  assign pif.flush       = (cur == FLUSH);
  assign pif.freeze      = (cur == MEM_WAIT) | (cur == ERR);
  assign pif.timeout_err = (cur == ERR);
  assign pif.hazard      = raw_match & (cur == RUN) & ~pif.branch_taken;
  assign pif.status_ld   = pif.exe_s & (cur == RUN) & ~pif.freeze;

endmodule

// File: tb/tb_exe_pipeline_ctrl.sv
// Bench for exe_pipeline_ctrl: directed literal checks plus randomized traffic against a cycle model.
module tb_exe_pipeline_ctrl;
  localparam int FC = 2;
  localparam int MT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  exe_pipeline_ctrl_if bus();

  exe_pipeline_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .pif (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pipeline condition described as counters/flags rather than states.
  bit m_ok = 0;
  bit m_err, m_wait, m_pend;
  int m_wait_cnt, m_flush_left;

  function automatic bit model_raw();
    bit e1, e2, m1, m2;
`ifdef FORWARDING_EN
    e1 = bus.exe_mem_read && bus.exe_wb_en && bus.src1 == bus.exe_dest;
    e2 = bus.exe_mem_read && bus.exe_wb_en && bus.src2 == bus.exe_dest;
    m1 = 0;
    m2 = 0;
`else
    e1 = bus.exe_wb_en && bus.src1 == bus.exe_dest;
    e2 = bus.exe_wb_en && bus.src2 == bus.exe_dest;
    m1 = bus.mem_wb_en && bus.src1 == bus.mem_dest;
    m2 = bus.mem_wb_en && bus.src2 == bus.mem_dest;
`endif
    return bus.id_valid && (e1 || m1 || (bus.two_src && (e2 || m2)));
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        bit run;
        int exp_state;
        run = !m_err && !m_wait && m_flush_left == 0;
        exp_state = m_err ? 3 : m_wait ? 2 : (m_flush_left > 0) ? 1 : 0;
        chk("cmp_state",   bus.state,       8'(exp_state));
        chk("cmp_flush",   bus.flush,       8'(exp_state == 1));
        chk("cmp_freeze",  bus.freeze,      8'(m_wait || m_err));
        chk("cmp_tmo",     bus.timeout_err, 8'(m_err));
        chk("cmp_hazard",  bus.hazard,      8'(run && !bus.branch_taken && model_raw()));
        chk("cmp_status",  bus.status_ld,   8'(run && bus.exe_s));
      end
      @(posedge clk);
      if (rst) begin
        m_ok = 1; m_err = 0; m_wait = 0; m_pend = 0; m_wait_cnt = 0; m_flush_left = 0;
      end else if (m_ok) begin
        if (m_err) begin
          m_err = 1;
        end else if (m_wait) begin
          if (bus.mem_ready) begin
            m_wait = 0;
            if (m_pend) begin m_flush_left = FC; m_pend = 0; end
          end else if (m_wait_cnt == MT - 1) begin
            m_wait = 0; m_err = 1;
          end else begin
            m_wait_cnt++;
          end
        end else if (m_flush_left > 0) begin
          m_flush_left--;
        end else if (bus.mem_req) begin
          m_wait = 1; m_wait_cnt = 0; m_pend = bus.branch_taken;
        end else if (bus.branch_taken) begin
          m_flush_left = FC;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic v);
    bus.id_valid = v; bus.src1 = {4{v}}; bus.src2 = {4{v}}; bus.two_src = v;
    bus.exe_wb_en = v; bus.exe_dest = {4{v}}; bus.exe_mem_read = v;
    bus.mem_wb_en = v; bus.mem_dest = {4{v}}; bus.branch_taken = v;
    bus.exe_s = v; bus.mem_req = v; bus.mem_ready = v;
  endtask

  bit fwd;

  initial begin
`ifdef FORWARDING_EN
    fwd = 1;
`else
    fwd = 0;
`endif
    // Reset with every input high, then release with inputs low.
    rst = 1; set_all(1'b1);
    step(); step();
    rst = 0; set_all(1'b0);
    @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_hazard", bus.hazard, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_freeze", bus.freeze, 0);
    chk("rst_status", bus.status_ld, 0);
    chk("rst_tmo", bus.timeout_err, 0);

    // RAW: EXE ALU result, EXE load, MEM-stage src2 match.
    step(); bus.id_valid = 1; bus.src1 = 3; bus.exe_wb_en = 1; bus.exe_dest = 3;
    @(negedge clk); chk("raw_exe_alu", bus.hazard, fwd ? 0 : 1);
    step(); bus.exe_mem_read = 1;
    @(negedge clk); chk("raw_exe_load", bus.hazard, 1);
    step(); set_all(0); bus.id_valid = 1; bus.src1 = 1; bus.src2 = 5; bus.two_src = 1;
    bus.mem_wb_en = 1; bus.mem_dest = 5;
    @(negedge clk); chk("raw_mem_src2", bus.hazard, fwd ? 0 : 1);
    step(); bus.two_src = 0;
    @(negedge clk); chk("raw_src2_unused", bus.hazard, 0);

    // Taken branch with a matching load in EXE.
    step(); set_all(0); bus.id_valid = 1; bus.src1 = 3; bus.exe_wb_en = 1;
    bus.exe_dest = 3; bus.exe_mem_read = 1; bus.branch_taken = 1;
    @(negedge clk); chk("br_hazard_n", bus.hazard, 0); chk("br_flush_n", bus.flush, 0);
    step(); bus.branch_taken = 0;
    @(negedge clk); chk("br_flush_n1", bus.flush, 1); chk("br_state_n1", bus.state, 1);
    chk("br_hazard_n1", bus.hazard, 0);
    step();
    @(negedge clk); chk("br_flush_n2", bus.flush, 1); chk("br_hazard_n2", bus.hazard, 0);
    step();
    @(negedge clk); chk("br_flush_n3", bus.flush, 0); chk("br_state_n3", bus.state, 0);
    chk("br_hazard_n3", bus.hazard, 1);

    // Memory wait, ready on the last allowed count, exe_s held high.
    step(); set_all(0); bus.exe_s = 1; bus.mem_req = 1;
    @(negedge clk); chk("mw_status_req", bus.status_ld, 1); chk("mw_freeze_req", bus.freeze, 0);
    step(); bus.mem_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_freeze", bus.freeze, 1); chk("mw_status", bus.status_ld, 0); chk("mw_state", bus.state, 2);
      step();
    end
    bus.mem_ready = 1;
    @(negedge clk); chk("mw_freeze_rdy", bus.freeze, 1); chk("mw_status_rdy", bus.status_ld, 0);
    step(); bus.mem_ready = 0;
    @(negedge clk); chk("mw_freeze_exit", bus.freeze, 0); chk("mw_state_exit", bus.state, 0);
    chk("mw_status_exit", bus.status_ld, 1);

    // Memory request together with a taken branch.
    step(); set_all(0); bus.mem_req = 1; bus.branch_taken = 1;
    @(negedge clk); chk("mb_freeze0", bus.freeze, 0);
    step(); set_all(0);
    @(negedge clk); chk("mb_freeze1", bus.freeze, 1); chk("mb_flush1", bus.flush, 0);
    step(); bus.mem_ready = 1;
    @(negedge clk); chk("mb_freeze2", bus.freeze, 1);
    step(); bus.mem_ready = 0;
    @(negedge clk); chk("mb_flush3", bus.flush, 1); chk("mb_freeze3", bus.freeze, 0);
    step();
    @(negedge clk); chk("mb_flush4", bus.flush, 1);
    step();
    @(negedge clk); chk("mb_state5", bus.state, 0); chk("mb_flush5", bus.flush, 0);

    // Timeout into ERR, sticky until reset.
    step(); set_all(0); bus.mem_req = 1;
    step(); bus.mem_req = 0;
    for (int i = 0; i < MT; i++) begin
      @(negedge clk); chk("to_wait_state", bus.state, 2); chk("to_wait_err", bus.timeout_err, 0);
      step();
    end
    @(negedge clk); chk("to_state", bus.state, 3); chk("to_err", bus.timeout_err, 1);
    chk("to_freeze", bus.freeze, 1);
    for (int i = 0; i < 3; i++) begin
      step(); bus.mem_ready = 1; bus.mem_req = 1; bus.branch_taken = 1;
      @(negedge clk); chk("to_sticky", bus.state, 3); chk("to_sticky_err", bus.timeout_err, 1);
    end
    step(); set_all(0); rst = 1;
    step(); rst = 0;
    @(negedge clk); chk("to_rst_state", bus.state, 0); chk("to_rst_err", bus.timeout_err, 0);
    chk("to_rst_freeze", bus.freeze, 0);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      step();
      rst              = ($urandom_range(0, 299) == 0);
      bus.id_valid     = $urandom_range(0, 1);
      bus.src1         = 4'($urandom_range(0, 3));
      bus.src2         = 4'($urandom_range(0, 3));
      bus.two_src      = $urandom_range(0, 1);
      bus.exe_wb_en    = $urandom_range(0, 1);
      bus.exe_dest     = 4'($urandom_range(0, 3));
      bus.exe_mem_read = $urandom_range(0, 1);
      bus.mem_wb_en    = $urandom_range(0, 1);
      bus.mem_dest     = 4'($urandom_range(0, 3));
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      bus.exe_s        = $urandom_range(0, 1);
      bus.mem_req      = ($urandom_range(0, 7) == 0);
      bus.mem_ready    = ($urandom_range(0, 4) == 0);
    end
    step(); rst = 0; set_all(0);
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
